riscv_mem_arbiter: RTL
======================

Name: riscv_mem_arbiter

Overview:
- Shares one memory/peripheral bus port between two requesters: data LSU (port D) and instruction fetch (port I).
- The bus port has the same req/we/be/addr/wdata/rdata style as the LSU peripheral side, plus a grant and a response-valid.
- Sits between the core (LSU, fetch unit) and the unified memory/interconnect.
- Arbitrates requests, tracks outstanding transactions in order and routes each response back to its owner.

Parameters:
- XLEN, 32, data/address width; byte-enable width is XLEN/8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (power of two, >=1).
- FIXED_PRIO, 0, selects the arbitration policy: 0 = round-robin; 1 = port D always wins.

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- d_req_i  in  1  data request
- d_we_i  in  1  data write enable
- d_be_i  in  XLEN/8  data byte enables
- d_addr_i  in  XLEN  data address
- d_wdata_i  in  XLEN  data write data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response valid
- d_rdata_o  out  XLEN  data read data
- i_req_i  in  1  fetch request (read-only)
- i_addr_i  in  XLEN  fetch address
- i_gnt_o  out  1  fetch request accepted
- i_rvalid_o  out  1  fetch response valid
- i_rdata_o  out  XLEN  fetch read data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write enable
- mem_be_o  out  XLEN/8  bus byte enables (all ones for fetch)
- mem_addr_o  out  XLEN  bus address
- mem_wdata_o  out  XLEN  bus write data (zero for fetch)
- mem_gnt_i  in  1  bus accepts request
- mem_rvalid_i  in  1  bus response; one per accepted request (reads and writes), in order
- mem_rdata_i  in  XLEN  bus read data
- resp_err_o  out  1  sticky flag: response arrived with nothing outstanding

Behaviour:
- Reset (async, rstn_i low):
  - Outstanding count = 0, owner FIFO empty, lock cleared, RR pointer = D.
  - resp_err_o = 0; all gnt/rvalid outputs = 0.
- Handshake:
  - A transaction is accepted when mem_req_o && mem_gnt_i; x_gnt_o is asserted in that same cycle, combinationally.
  - A requester holds its req and payload stable until it is granted.
- Arbitration:
  - The arbiter is blocked when count == MAX_OUTSTANDING. While blocked, mem_req_o = 0 and neither port is granted, even if a response retires in the same cycle (no bypass).
  - When not blocked, the selected port is chosen as follows:
    - Lock set: the locked port.
    - Only one request active: that port.
    - Both requests active: FIXED_PRIO=1 selects D; otherwise the port the RR pointer indicates.
  - mem_* outputs mux the selected port's payload. For fetch: mem_we_o = 0, mem_be_o = all ones, mem_wdata_o = 0.
- Lock (state IDLE/LOCKED):
  - IDLE -> LOCKED when mem_req_o && !mem_gnt_i; the selected owner is recorded.
  - LOCKED -> IDLE on acceptance.
  - While LOCKED the other port is never selected, so the bus payload does not change under a pending request.
- RR pointer: on every acceptance it moves to the port not granted.
- Owner FIFO (depth MAX_OUTSTANDING, 1-bit owner IDs):
  - Push on acceptance; pop on mem_rvalid_i.
  - Simultaneous push and pop keeps count unchanged.
- Response routing (combinational from mem_rvalid_i and the FIFO head):
  - Head = D: d_rvalid_o = mem_rvalid_i.
  - Head = I: i_rvalid_o = mem_rvalid_i.
  - Both rdata outputs carry mem_rdata_i unmasked.
  - Write responses are also routed to D, so the LSU can retire the store.
- Zero-latency case: mem_rvalid_i in the cycle after the grant produces x_rvalid_o in that cycle.
- Spurious response (mem_rvalid_i with FIFO empty): no rvalid is asserted, resp_err_o sets and stays set until reset, and count stays 0.
- Request dropped before grant while LOCKED: protocol violation. The lock still holds until acceptance; an SVA checks for it.

Decomposition:
- riscv_arb_pkg holds:
  - typedef enum logic {OWN_D, OWN_I} arb_owner_t
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t
  - localparam for the count width
- Sub-module riscv_arb_owner_fifo (parameterised depth, push/pop/full/empty/head). Holds all pointer wrap-around logic; the top level holds the arbitration, lock and muxes.

Test Plan:
- Only d_req_i=1, addr=0x100, we=1, be=0011, mem_gnt_i=1 -> d_gnt_o=1 that cycle; mem_addr_o=0x100, mem_be_o=0011; the next mem_rvalid_i gives d_rvalid_o=1, i_rvalid_o=0.
- Both requests held, FIXED_PRIO=0, mem_gnt_i=1, responses returned every cycle -> grants alternate D,I,D,I; responses routed D,I,D,I with rdata 0xA,0xB,0xC,0xD passed through.
- FIXED_PRIO=1, both requests held -> D granted every cycle; I starves until d_req_i drops.
- I selected, mem_gnt_i=0 for 3 cycles, d_req_i rises in cycle 1 -> mem_addr_o stays at the I address all 3 cycles; I granted on cycle 4; D granted afterwards.
- MAX_OUTSTANDING=2, two grants with no response -> mem_req_o=0 and gnts=0; a response in the same cycle gives no grant; a grant occurs on the next cycle.
- mem_rvalid_i with nothing outstanding -> resp_err_o=1 sticky, no rvalid outputs; async reset mid-transaction clears count, lock and resp_err_o immediately.

Source files
------------

// File: rtl/riscv_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   arb_owner_t   : owner ID stored per outstanding transaction (D = LSU, I = fetch)
//   arb_state_t   : lock state of the arbiter
//   arb_cnt_width : width needed to count 0..depth outstanding transactions
package riscv_arb_pkg;

  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} arb_owner_t;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;

  function automatic int arb_cnt_width(int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int ARB_MAX_OUTSTANDING = 2;
  localparam int ARB_CNT_W           = arb_cnt_width(ARB_MAX_OUTSTANDING);

endpackage

// File: rtl/riscv_arb_owner_fifo.sv
// In-order owner FIFO: remembers which port owns each outstanding bus
// transaction so responses can be routed back.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push, push_owner : record a newly accepted transaction
//   pop           : retire the oldest transaction (ignored when empty)
//   full, empty   : occupancy flags
//   head          : owner of the oldest outstanding transaction
module riscv_arb_owner_fifo
  import riscv_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       push,
  input  arb_owner_t push_owner,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output arb_owner_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = arb_cnt_width(DEPTH);

  arb_owner_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  // Explicit wrap keeps the pointers correct for any depth, including 1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= push_owner;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-port memory bus arbiter: LSU (D) and instruction fetch (I) share one
// req/gnt/rvalid bus port. Responses return in order and are routed by the
// owner FIFO.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   d_*                  : LSU request/response port
//   i_*                  : fetch request/response port (read-only)
//   mem_*                : shared bus port
//   resp_err_o           : sticky, set by a response with nothing outstanding
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit FIXED_PRIO      = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [XLEN/8-1:0] d_be_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [XLEN-1:0]   d_rdata_o,
  input  logic              i_req_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [XLEN-1:0]   i_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              resp_err_o
);

  arb_state_t state_reg;
  arb_owner_t lock_owner_reg;
  arb_owner_t rr_ptr_reg;
  logic       resp_err_reg;

  arb_owner_t sel;
  arb_owner_t head;
  logic       sel_req, blocked, accept, full, empty;

  riscv_arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push       (accept),
    .push_owner (sel),
    .pop        (mem_rvalid_i),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

  // Blocking looks only at the registered count; a response retiring in the
  // same cycle does not free a slot until the next cycle.
  assign blocked = full;

  always_comb begin
    sel = OWN_D;
    if (state_reg == ARB_LOCKED)      sel = lock_owner_reg;
    else if (d_req_i && !i_req_i)     sel = OWN_D;
    else if (i_req_i && !d_req_i)     sel = OWN_I;
    else if (d_req_i && i_req_i)      sel = FIXED_PRIO ? OWN_D : rr_ptr_reg;
  end

  assign sel_req   = (sel == OWN_D) ? d_req_i : i_req_i;
  assign mem_req_o = sel_req && !blocked;
  assign accept    = mem_req_o && mem_gnt_i;
  assign d_gnt_o   = accept && (sel == OWN_D);
  assign i_gnt_o   = accept && (sel == OWN_I);

  always_comb begin
    if (sel == OWN_D) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = '1;
      mem_addr_o  = i_addr_i;
      mem_wdata_o = '0;
    end
  end

  // Writes are routed by owner like reads, so stores retire on the D port.
  assign d_rvalid_o = mem_rvalid_i && !empty && (head == OWN_D);
  assign i_rvalid_o = mem_rvalid_i && !empty && (head == OWN_I);
  assign d_rdata_o  = mem_rdata_i;
  assign i_rdata_o  = mem_rdata_i;
  assign resp_err_o = resp_err_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg      <= ARB_IDLE;
      lock_owner_reg <= OWN_D;
      rr_ptr_reg     <= OWN_D;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (mem_req_o && !mem_gnt_i) begin
            state_reg      <= ARB_LOCKED;
            lock_owner_reg <= sel;
          end
        end
        ARB_LOCKED: begin
          if (accept) state_reg <= ARB_IDLE;
        end
        default: state_reg <= ARB_IDLE;
      endcase
      if (accept) rr_ptr_reg <= (sel == OWN_D) ? OWN_I : OWN_D;
      if (mem_rvalid_i && empty) resp_err_reg <= 1'b1;
    end
  end

  // A locked requester must keep requesting until it is accepted.
  a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (state_reg == ARB_LOCKED) |-> sel_req);

endmodule
